thumb_halfword_fetch: RTL and testbench
=======================================

Name: thumb_halfword_fetch

Overview:
- Instruction-fetch front end that produces the `code`/`addr1` pair consumed by the Thumb command decoder.
- Fetches aligned 32-bit words from instruction memory and presents them one instruction at a time, in ARM mode (one word each) or Thumb mode (two halfwords each).
- Tracks the fetch PC, handles branch redirects and mode switches, and discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] forced to 0).
- RESET_THUMB, 1'b0, instruction set after reset (1 = Thumb).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- redirect  input  1  branch/exception redirect strobe
- redirect_pc  input  32  new instruction address
- redirect_thumb  input  1  instruction set after redirect (1 = Thumb)
- mem_req  output  1  fetch request, held until acknowledged
- mem_addr  output  32  word-aligned fetch address, stable while mem_req=1
- mem_ack  input  1  request accepted; mem_rdata valid this cycle
- mem_rdata  input  32  fetched word
- out_valid  output  1  instruction available to decoder
- out_ready  input  1  decoder accepts instruction
- out_code  output  32  buffered fetch word (decoder `code`)
- out_addr1  output  1  halfword select (decoder `addr1`), 0 in ARM mode
- out_thumb  output  1  current instruction set
- out_pc  output  32  address of presented instruction

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high and wins over every other input.
  - Reset values: state=IDLE, pc=RESET_PC&~3, thumb=RESET_THUMB, squash=0, mem_req=0, mem_addr=0, out_valid=0, out_code=0, out_addr1=0, out_pc=0.
  - out_thumb = RESET_THUMB.
- State machine: IDLE, FETCH, HOLD.
  - IDLE -> FETCH unconditionally on the next cycle.
  - FETCH: mem_req=1, and mem_addr holds {fetch_pc[31:2],2'b00}, latched on FETCH entry.
    - On mem_ack with squash=0: out_code<=mem_rdata, go to HOLD.
    - On mem_ack with squash=1: drop the data, clear squash, latch the new fetch address, stay in FETCH (mem_req stays high; new address valid the next cycle).
  - HOLD: out_valid=1, out_pc=pc, out_addr1=thumb&pc[1].
    - While out_valid=1 and out_ready=0, every output stays stable.
- Accept (out_valid & out_ready, no redirect):
  - ARM: pc<=pc+4, go to FETCH.
  - Thumb with pc[1]=0: pc<=pc+2, stay in HOLD with no memory access; the upper halfword is presented the next cycle.
  - Thumb with pc[1]=1: pc<=pc+2, go to FETCH.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32; 0xFFFF_FFFE+2 = 0.
  - pc[0] is always 0.
  - In ARM mode pc[1] is always 0.
- Redirect (highest priority after reset):
  - pc<=redirect_pc&~1 in Thumb, or redirect_pc&~3 in ARM.
  - thumb<=redirect_thumb.
  - out_valid drops the next cycle.
  - An accept in the same cycle is ignored for PC update.
  - From HOLD or IDLE: go to FETCH, with mem_addr = new word address the next cycle.
  - From FETCH with mem_ack low: set squash, keep mem_addr unchanged (protocol), stay in FETCH.
  - From FETCH with mem_ack high in the same cycle: the data is discarded and the new fetch address is latched; no squash needed.
  - Repeated redirects while squash=1: the latest pc wins; a single squash covers them.
- Latency:
  - Redirect at T with immediate ack -> mem_req with the new address at T+1, ack at T+1 -> out_valid at T+2.
  - Thumb word: two instructions per fetch.
  - Back-to-back accepts: one instruction per cycle within a word, plus fetch latency between words.
- Other rules:
  - mem_ack outside FETCH is ignored.
  - At most one outstanding request.

Test Plan:
- Reset, RESET_PC=0, ARM, mem_ack the cycle after each req with 0xE3A0_0001/0xE3A0_0002, out_ready=1 -> mem_addr 0 then 4; out_code sequence 0xE3A00001 (pc 0) then 0xE3A00002 (pc 4); out_addr1=0.
- Redirect to 0x100 Thumb, word 0x4148_1C4A -> outputs (pc 0x100, addr1 0) then (pc 0x102, addr1 1) on consecutive cycles; only one memory request for 0x100.
- Redirect to 0x202 Thumb -> fetch 0x200; first output is pc 0x202 with addr1=1; the next request is 0x204.
- Redirect to 0x300 while a request to 0x10 is outstanding, ack 3 cycles later -> that data is never presented; the next request is 0x300; out_valid first rises with pc 0x300.
- out_ready low for 5 cycles in HOLD -> out_code/out_pc/out_addr1 stable, no mem_req, pc unchanged.
- Thumb pc 0xFFFF_FFFC, accept twice -> second output pc 0xFFFF_FFFE; next request mem_addr 0x0000_0000 (wrap).

Source files
------------

// File: rtl/thumb_halfword_fetch.sv
// Instruction-fetch front end: fetches aligned words and presents them one ARM
// word or one Thumb halfword at a time, with redirect and stale-fetch squashing.
module thumb_halfword_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic        RESET_THUMB = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_thumb,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_code,
    output logic        out_addr1,
    output logic        out_thumb,
    output logic [31:0] out_pc
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        thumb, thumb_d;
    logic        squash, squash_d;
    logic [31:0] fetch_addr, fetch_addr_d;
    logic [31:0] code, code_d;

    logic [31:0] redir_pc;
    logic [31:0] pc_inc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    assign redir_pc = redirect_thumb ? {redirect_pc[31:1], 1'b0}
                                     : {redirect_pc[31:2], 2'b00};
    assign pc_inc   = pc + (thumb ? 32'd2 : 32'd4);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state;
        pc_d         = pc;
        thumb_d      = thumb;
        squash_d     = squash;
        fetch_addr_d = fetch_addr;
        code_d       = code;

        // A redirect overrides any same-cycle accept for the PC update.
        if (redirect) begin
            pc_d    = redir_pc;
            thumb_d = redirect_thumb;
        end

        case (state)
            IDLE: begin
                state_d      = FETCH;
                fetch_addr_d = word_of(pc_d);
            end
            FETCH: begin
                if (mem_ack) begin
                    if (redirect || squash) begin
                        // Stale word: drop it and restart at the current PC.
                        squash_d     = 1'b0;
                        fetch_addr_d = word_of(pc_d);
                    end else begin
                        code_d  = mem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // Request must stay stable until acked; squash its data.
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d      = FETCH;
                    fetch_addr_d = word_of(pc_d);
                end else if (out_ready) begin
                    pc_d = pc_inc;
                    // Lower Thumb halfword: upper half is already buffered.
                    if (!(thumb && !pc[1])) begin
                        state_d      = FETCH;
                        fetch_addr_d = word_of(pc_inc);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC_ALIGNED;
            thumb      <= RESET_THUMB;
            squash     <= 1'b0;
            fetch_addr <= '0;
            code       <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            thumb      <= thumb_d;
            squash     <= squash_d;
            fetch_addr <= fetch_addr_d;
            code       <= code_d;
        end
    end

    assign mem_req   = (state == FETCH);
    assign mem_addr  = fetch_addr;
    assign out_valid = (state == HOLD);
    assign out_code  = code;
    assign out_pc    = out_valid ? pc : '0;
    assign out_addr1 = out_valid & thumb & pc[1];
    assign out_thumb = thumb;

endmodule

// File: tb/tb_thumb_halfword_fetch.sv
// Directed bench for thumb_halfword_fetch: a memory responder with adjustable
// ack latency plus scoreboards for fetch addresses and accepted instructions.
module tb_thumb_halfword_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic        addr1;
        logic [31:0] code;
        logic        thumb;
    } exp_out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_thumb;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_code;
    logic        out_addr1;
    logic        out_thumb;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    exp_out_t    exp_out_q[$];

    int          ack_delay = 1;
    int          wait_cnt  = 0;
    int          idle_cnt  = 0;
    logic        chk_reset = 1'b0;
    logic        chk_stall = 1'b0;
    exp_out_t    stall_exp;

    thumb_halfword_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .redirect_thumb(redirect_thumb),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_code      (out_code),
        .out_addr1     (out_addr1),
        .out_thumb     (out_thumb),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hE3A0_0001;
            32'h0000_0004: return 32'hE3A0_0002;
            32'h0000_0100: return 32'h4148_1C4A;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after ack_delay waiting cycles of a request.
    always @(posedge clk) begin
        #1;
        if (mem_ack) wait_cnt = 0;
        mem_ack   = mem_req && (wait_cnt >= ack_delay);
        mem_rdata = mem_word(mem_addr);
        if (mem_req && !mem_ack) wait_cnt++;
    end

    // All comparisons happen here, away from the active edge.
    always @(negedge clk) begin
        exp_out_t e;
        logic [31:0] a;
        if (chk_reset) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_mem_req",   32'(mem_req),   32'd0);
            check("rst_mem_addr",  mem_addr,       32'd0);
            check("rst_out_code",  out_code,       32'd0);
            check("rst_out_pc",    out_pc,         32'd0);
            check("rst_out_addr1", 32'(out_addr1), 32'd0);
            check("rst_out_thumb", 32'(out_thumb), 32'd0);
        end
        if (chk_stall) begin
            check("stall_valid",   32'(out_valid), 32'd1);
            check("stall_mem_req", 32'(mem_req),   32'd0);
            check("stall_pc",      out_pc,         stall_exp.pc);
            check("stall_code",    out_code,       stall_exp.code);
            check("stall_addr1",   32'(out_addr1), 32'(stall_exp.addr1));
        end
        if (mem_req && mem_ack) begin
            idle_cnt = 0;
            if (exp_addr_q.size() == 0) begin
                check("req_extra", 32'(exp_addr_q.size()), 32'd1);
            end else begin
                a = exp_addr_q.pop_front();
                check("req_addr", mem_addr, a);
            end
        end
        if (out_valid && out_ready) begin
            idle_cnt = 0;
            if (exp_out_q.size() == 0) begin
                check("out_extra", 32'(exp_out_q.size()), 32'd1);
            end else begin
                e = exp_out_q.pop_front();
                check("out_pc",    out_pc,         e.pc);
                check("out_addr1", 32'(out_addr1), 32'(e.addr1));
                check("out_code",  out_code,       e.code);
                check("out_thumb", 32'(out_thumb), 32'(e.thumb));
            end
        end
        if (exp_addr_q.size() != 0 || exp_out_q.size() != 0) begin
            idle_cnt++;
            if (idle_cnt > 100) begin
                check("watchdog_pending", 32'(exp_addr_q.size() + exp_out_q.size()), 32'd0);
                exp_addr_q.delete();
                exp_out_q.delete();
                idle_cnt = 0;
            end
        end else begin
            idle_cnt = 0;
        end
    end

    task automatic push_out(input logic [31:0] pc, input logic thumb);
        exp_out_t e;
        e.pc    = pc;
        e.addr1 = thumb & pc[1];
        e.code  = mem_word({pc[31:2], 2'b00});
        e.thumb = thumb;
        exp_out_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until both scoreboards drain; stops accepting once outputs are done.
    task automatic wait_empty();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (exp_out_q.size() == 0) out_ready = 1'b0;
            if (exp_out_q.size() == 0 && exp_addr_q.size() == 0) return;
        end
        $display("FAIL wait_empty timeout pending=%0d", exp_addr_q.size() + exp_out_q.size());
        $fatal(1, "scoreboard did not drain");
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic thumb);
        tick();
        redirect       = 1'b1;
        redirect_pc    = pc;
        redirect_thumb = thumb;
        out_ready      = 1'b0;
        tick();
        redirect  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        redirect_thumb = 1'b0;
        out_ready      = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset = 1'b1;
        tick();
        tick();
        chk_reset = 1'b0;

        // ARM sequential fetch from reset
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_out(32'h0, 1'b0);
        push_out(32'h4, 1'b0);
        rst       = 1'b0;
        out_ready = 1'b1;
        wait_empty();

        // Thumb word: two halfwords from one fetch
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h104);
        push_out(32'h100, 1'b1);
        push_out(32'h102, 1'b1);
        do_redirect(32'h100, 1'b1);
        wait_empty();

        // Thumb redirect into the upper halfword
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h204);
        push_out(32'h202, 1'b1);
        do_redirect(32'h202, 1'b1);
        wait_empty();

        // Redirect while a slow fetch is outstanding: its data is squashed
        ack_delay = 3;
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h300);
        exp_addr_q.push_back(32'h304);
        push_out(32'h300, 1'b0);
        tick();
        redirect       = 1'b1;
        redirect_pc    = 32'h10;
        redirect_thumb = 1'b0;
        out_ready      = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h302;
        tick();
        redirect  = 1'b0;
        out_ready = 1'b1;
        wait_empty();

        // Back-pressure: everything stable, no fetch, PC held
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        stall_exp.pc    = 32'h304;
        stall_exp.addr1 = 1'b0;
        stall_exp.code  = mem_word(32'h304);
        stall_exp.thumb = 1'b0;
        chk_stall = 1'b1;
        repeat (5) tick();
        chk_stall = 1'b0;
        ack_delay = 1;
        exp_addr_q.push_back(32'h308);
        push_out(32'h304, 1'b0);
        out_ready = 1'b1;
        wait_empty();

        // Thumb PC wrap at the top of the address space
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        push_out(32'hFFFF_FFFC, 1'b1);
        push_out(32'hFFFF_FFFE, 1'b1);
        do_redirect(32'hFFFF_FFFC, 1'b1);
        wait_empty();

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
